// File: rtl/rs485_pkg.sv
// Shared definitions for the RS-485 / Modbus RTU screen interface:
// function codes, exception and frame-error codes, FSM states and the CRC16 step.
package rs485_pkg;

  localparam logic [7:0] FC_READ_HOLD    = 8'h03;
  localparam logic [7:0] FC_WRITE_SINGLE = 8'h06;

  localparam logic [7:0] EXC_ILLEGAL_FUNC  = 8'h01;
  localparam logic [7:0] EXC_ILLEGAL_VALUE = 8'h03;

  localparam logic [1:0] ERR_CRC   = 2'd0;
  localparam logic [1:0] ERR_GAP   = 2'd1;
  localparam logic [1:0] ERR_OVF   = 2'd2;
  localparam logic [1:0] ERR_SHORT = 2'd3;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  typedef enum logic [1:0] {
    S_WAIT_IDLE = 2'd0,
    S_IDLE      = 2'd1,
    S_RECV      = 2'd2,
    S_CHECK     = 2'd3
  } rx_state_e;

  // One byte of reflected Modbus CRC16, LSB of the byte shifted first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/modbus_crc16.sv
// Byte-wide Modbus CRC16 accumulator; also used by the response transmitter.
// i_init together with i_valid seeds the register and folds the first byte in one cycle.
module modbus_crc16
  import rs485_pkg::*;
(
  input  logic        i_clk,
  input  logic        rst_n,
  input  logic        i_init,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic [15:0] o_crc
);

  logic [15:0] crc_reg;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_reg <= CRC_INIT;
    end else if (i_valid) begin
      crc_reg <= crc16_byte(i_init ? CRC_INIT : crc_reg, i_data);
    end else if (i_init) begin
      crc_reg <= CRC_INIT;
    end
  end

  assign o_crc = crc_reg;

endmodule

// File: rtl/modbus_rtu_rx_framer.sv
// Modbus RTU receive framer: delimits frames by bus silence, checks CRC and address,
// and decodes FC03/FC06 into a one-cycle command pulse (or exception / frame error).
module modbus_rtu_rx_framer
  import rs485_pkg::*;
#(
  parameter int         CLK_HZ     = 29_491_200,
  parameter int         BAUD       = 9600,
  parameter logic [7:0] SLAVE_ADDR = 8'h01,
  parameter int         MAX_LEN    = 16
) (
  input  logic        i_clk,
  input  logic        rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_tx_busy,
  output logic        o_cmd_valid,
  output logic [7:0]  o_func,
  output logic [15:0] o_reg_addr,
  output logic [15:0] o_reg_data,
  output logic        o_broadcast,
  output logic        o_exc_valid,
  output logic [7:0]  o_exc_code,
  output logic        o_frame_err,
  output logic [1:0]  o_err_code
);

  // 64-bit intermediates: CLK_HZ*77 overflows a 32-bit int at the default clock.
  localparam longint T15_L   = (longint'(CLK_HZ) * 33) / (2 * longint'(BAUD));
  localparam longint T35_L   = (longint'(CLK_HZ) * 77) / (2 * longint'(BAUD));
  localparam int     T15_CYC = int'(T15_L);
  localparam int     T35_CYC = int'(T35_L);

  localparam int TMR_W = $clog2(T35_CYC + 1);
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = $clog2(MAX_LEN);

  localparam logic [TMR_W-1:0] T15_T   = TMR_W'(T15_CYC);
  localparam logic [TMR_W-1:0] T35_T   = TMR_W'(T35_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] LEN_MIN = CNT_W'(4);
  localparam logic [CNT_W-1:0] LEN_CMD = CNT_W'(8);

  rx_state_e         state_reg;
  logic [TMR_W-1:0]  timer_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              ovf_reg;
  logic              gap_reg;
  logic [7:0]        buf_reg [MAX_LEN];
  logic [15:0]       crc_value;

  logic              timer_max;
  logic              gap_hit;
  logic              crc_init;
  logic              crc_valid;
  logic              store_en;

  logic              v_cmd;
  logic              v_exc;
  logic              v_err;
  logic [7:0]        v_exc_code;
  logic [1:0]        v_err_code;
  logic              frm_bcast;
  logic              frm_addr_ok;
  logic              frm_fc_known;

  assign timer_max = (timer_reg == T35_T);
  assign gap_hit   = (timer_reg > T15_T);

  // Byte acceptance and CRC control; transmitter echo is never accepted.
  always_comb begin
    crc_init  = 1'b0;
    crc_valid = 1'b0;
    store_en  = 1'b0;
    if (!i_tx_busy && i_rx_valid) begin
      case (state_reg)
        S_IDLE: begin
          crc_init  = 1'b1;
          crc_valid = 1'b1;
          store_en  = 1'b1;
        end
        S_RECV: begin
          crc_valid = 1'b1;
          store_en  = (cnt_reg < CNT_MAX);
        end
        default: ;
      endcase
    end
  end

  modbus_crc16 u_crc (
    .i_clk   (i_clk),
    .rst_n   (rst_n),
    .i_init  (crc_init),
    .i_valid (crc_valid),
    .i_data  (i_rx_data),
    .o_crc   (crc_value)
  );

  // Frame bytes live in a plain array; cnt_reg is always 0 in S_IDLE.
  always_ff @(posedge i_clk) begin
    if (store_en) begin
      buf_reg[cnt_reg[IDX_W-1:0]] <= i_rx_data;
    end
  end

  assign frm_bcast    = (buf_reg[0] == 8'h00);
  assign frm_addr_ok  = (buf_reg[0] == SLAVE_ADDR) || frm_bcast;
  assign frm_fc_known = (buf_reg[1] == FC_READ_HOLD) || (buf_reg[1] == FC_WRITE_SINGLE);

  // Frame verdict, evaluated during the single S_CHECK cycle; errors outrank decoding.
  always_comb begin
    v_cmd      = 1'b0;
    v_exc      = 1'b0;
    v_err      = 1'b0;
    v_exc_code = EXC_ILLEGAL_FUNC;
    v_err_code = ERR_CRC;
    if (cnt_reg < LEN_MIN) begin
      v_err      = 1'b1;
      v_err_code = ERR_SHORT;
    end else if (ovf_reg) begin
      v_err      = 1'b1;
      v_err_code = ERR_OVF;
    end else if (gap_reg) begin
      v_err      = 1'b1;
      v_err_code = ERR_GAP;
    end else if (crc_value != 16'h0000) begin
      v_err      = 1'b1;
      v_err_code = ERR_CRC;
    end else if (frm_addr_ok) begin
      if (frm_fc_known) begin
        if (cnt_reg == LEN_CMD) begin
          v_cmd = !(frm_bcast && (buf_reg[1] == FC_READ_HOLD));
        end else begin
          v_exc      = !frm_bcast;
          v_exc_code = EXC_ILLEGAL_VALUE;
        end
      end else begin
        v_exc      = !frm_bcast;
        v_exc_code = EXC_ILLEGAL_FUNC;
      end
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_WAIT_IDLE;
      timer_reg   <= '0;
      cnt_reg     <= '0;
      ovf_reg     <= 1'b0;
      gap_reg     <= 1'b0;
      o_cmd_valid <= 1'b0;
      o_func      <= 8'h00;
      o_reg_addr  <= 16'h0000;
      o_reg_data  <= 16'h0000;
      o_broadcast <= 1'b0;
      o_exc_valid <= 1'b0;
      o_exc_code  <= 8'h00;
      o_frame_err <= 1'b0;
      o_err_code  <= 2'd0;
    end else begin
      o_cmd_valid <= 1'b0;
      o_exc_valid <= 1'b0;
      o_frame_err <= 1'b0;
      if (i_tx_busy) begin
        state_reg <= S_WAIT_IDLE;
        timer_reg <= '0;
        cnt_reg   <= '0;
        ovf_reg   <= 1'b0;
        gap_reg   <= 1'b0;
      end else begin
        if (i_rx_valid) begin
          timer_reg <= '0;
        end else if (!timer_max) begin
          timer_reg <= timer_reg + 1'b1;
        end

        case (state_reg)
          S_WAIT_IDLE: begin
            if (!i_rx_valid && timer_max) begin
              state_reg <= S_IDLE;
            end
          end
          S_IDLE: begin
            if (i_rx_valid) begin
              cnt_reg   <= CNT_W'(1);
              ovf_reg   <= 1'b0;
              gap_reg   <= 1'b0;
              state_reg <= S_RECV;
            end
          end
          S_RECV: begin
            // A byte in the same cycle as the silence limit still belongs to this frame.
            if (i_rx_valid) begin
              if (cnt_reg == CNT_MAX) begin
                ovf_reg <= 1'b1;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
              if (gap_hit) begin
                gap_reg <= 1'b1;
              end
            end else if (timer_max) begin
              state_reg <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (v_cmd) begin
              o_cmd_valid <= 1'b1;
              o_func      <= buf_reg[1];
              o_reg_addr  <= {buf_reg[2], buf_reg[3]};
              o_reg_data  <= {buf_reg[4], buf_reg[5]};
              o_broadcast <= frm_bcast;
            end
            if (v_exc) begin
              o_exc_valid <= 1'b1;
              o_exc_code  <= v_exc_code;
            end
            if (v_err) begin
              o_frame_err <= 1'b1;
              o_err_code  <= v_err_code;
            end
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            gap_reg   <= 1'b0;
            state_reg <= S_IDLE;
          end
          default: state_reg <= S_WAIT_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_modbus_rtu_rx_framer.sv
// Directed bench for modbus_rtu_rx_framer at 96 kHz / 9600 baud (T15 = 165, T35 = 385 clocks).
module tb_modbus_rtu_rx_framer;

  localparam int T15 = 165;
  localparam int T35 = 385;
  localparam int GAP = 100;

  logic        i_clk      = 1'b0;
  logic        rst_n      = 1'b0;
  logic [7:0]  i_rx_data  = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        i_tx_busy  = 1'b0;
  logic        o_cmd_valid;
  logic [7:0]  o_func;
  logic [15:0] o_reg_addr;
  logic [15:0] o_reg_data;
  logic        o_broadcast;
  logic        o_exc_valid;
  logic [7:0]  o_exc_code;
  logic        o_frame_err;
  logic [1:0]  o_err_code;

  always #5 i_clk = ~i_clk;

  modbus_rtu_rx_framer #(
    .CLK_HZ     (96_000),
    .BAUD       (9600),
    .SLAVE_ADDR (8'h01),
    .MAX_LEN    (16)
  ) dut (
    .i_clk       (i_clk),
    .rst_n       (rst_n),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .i_tx_busy   (i_tx_busy),
    .o_cmd_valid (o_cmd_valid),
    .o_func      (o_func),
    .o_reg_addr  (o_reg_addr),
    .o_reg_data  (o_reg_data),
    .o_broadcast (o_broadcast),
    .o_exc_valid (o_exc_valid),
    .o_exc_code  (o_exc_code),
    .o_frame_err (o_frame_err),
    .o_err_code  (o_err_code)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int neg_cyc  = 0;
  int byte_neg = 0;
  int cmd_neg  = 0;
  int n_cmd    = 0;
  int n_exc    = 0;
  int n_err    = 0;

  logic [7:0] frm[$];

  // Pulse monitor; a strobe seen here is sampled by the DUT at the following posedge.
  always @(negedge i_clk) begin
    neg_cyc++;
    if (i_rx_valid) byte_neg = neg_cyc + 1;
    if (o_cmd_valid) begin
      n_cmd++;
      cmd_neg = neg_cyc;
    end
    if (o_exc_valid) n_exc++;
    if (o_frame_err) n_err++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clk);
    #1;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  // Idle g cycles between strobes leaves the DUT timer at g+1 when the next byte lands.
  task automatic send_frame(input int slow_idx, input int slow_gap);
    for (int i = 0; i < frm.size(); i++) begin
      send_byte(frm[i]);
      if (i != frm.size() - 1) repeat ((i == slow_idx) ? slow_gap : GAP) @(posedge i_clk);
    end
  endtask

  // Bit-serial reference CRC, appended low byte first.
  task automatic add_crc();
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < frm.size(); i++) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ frm[i][j];
        c  = {1'b0, c[15:1]};
        if (fb) c = c ^ 16'hA001;
      end
    end
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
  endtask

  task automatic run_frame(input string tag, input int slow_idx, input int slow_gap,
                           input int e_cmd, input int e_exc, input int e_err);
    int c0, x0, r0;
    c0 = n_cmd;
    x0 = n_exc;
    r0 = n_err;
    send_frame(slow_idx, slow_gap);
    repeat (T35 + 10) @(posedge i_clk);
    #1;
    check_eq({tag, " cmd_pulses"}, n_cmd - c0, e_cmd);
    check_eq({tag, " exc_pulses"}, n_exc - x0, e_exc);
    check_eq({tag, " err_pulses"}, n_err - r0, e_err);
  endtask

  initial begin
    int c0, x0, r0;

    repeat (3) @(posedge i_clk);
    #1;
    check_eq("rst cmd_valid", o_cmd_valid, 0);
    check_eq("rst exc_valid", o_exc_valid, 0);
    check_eq("rst frame_err", o_frame_err, 0);
    check_eq("rst func", o_func, 0);
    check_eq("rst reg_addr", o_reg_addr, 0);
    check_eq("rst reg_data", o_reg_data, 0);
    check_eq("rst err_code", o_err_code, 0);
    rst_n = 1'b1;
    repeat (T35 + 10) @(posedge i_clk);

    frm = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    run_frame("fc03", -1, 0, 1, 0, 0);
    check_eq("fc03 func", o_func, 32'h03);
    check_eq("fc03 addr", o_reg_addr, 32'h0000);
    check_eq("fc03 data", o_reg_data, 32'h0001);
    check_eq("fc03 bcast", o_broadcast, 0);
    check_eq("fc03 latency", cmd_neg - byte_neg, T35 + 2);

    frm = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
    run_frame("fc06", -1, 0, 1, 0, 0);
    check_eq("fc06 func", o_func, 32'h06);
    check_eq("fc06 addr", o_reg_addr, 32'h0001);
    check_eq("fc06 data", o_reg_data, 32'h0003);
    check_eq("fc06 bcast", o_broadcast, 0);

    frm = '{8'h00, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03};
    add_crc();
    run_frame("bc06", -1, 0, 1, 0, 0);
    check_eq("bc06 bcast", o_broadcast, 1);
    check_eq("bc06 func", o_func, 32'h06);

    frm = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0B};
    run_frame("badcrc", -1, 0, 0, 0, 1);
    check_eq("badcrc code", o_err_code, 0);

    frm = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    run_frame("gap200", 2, 200, 0, 0, 1);
    check_eq("gap200 code", o_err_code, 1);
    run_frame("gap_at_t15", 2, T15 - 1, 1, 0, 0);
    run_frame("gap_over_t15", 2, T15, 0, 0, 1);
    check_eq("gap_over_t15 code", o_err_code, 1);
    // Byte lands when the timer sits one below T35: it joins the frame (as a gap error).
    run_frame("gap_t35_edge", 2, T35 - 2, 0, 0, 1);
    check_eq("gap_t35_edge code", o_err_code, 1);

    frm = {};
    for (int i = 0; i < 20; i++) frm.push_back(8'(i + 1));
    run_frame("ovf20", -1, 0, 0, 0, 1);
    check_eq("ovf20 code", o_err_code, 2);

    frm = '{8'h01, 8'h03};
    run_frame("short2", -1, 0, 0, 0, 1);
    check_eq("short2 code", o_err_code, 3);

    frm = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01};
    add_crc();
    run_frame("fc04", -1, 0, 0, 1, 0);
    check_eq("fc04 exc_code", o_exc_code, 32'h01);

    frm = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    add_crc();
    run_frame("fc03_len9", -1, 0, 0, 1, 0);
    check_eq("fc03_len9 exc_code", o_exc_code, 32'h03);

    frm = '{8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
    add_crc();
    run_frame("addr02", -1, 0, 0, 0, 0);

    frm = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
    add_crc();
    run_frame("bc03", -1, 0, 0, 0, 0);

    frm = '{8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01};
    add_crc();
    run_frame("bc04", -1, 0, 0, 0, 0);

    // Transmitter busy mid-frame, then a frame without prior bus silence.
    frm = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    c0 = n_cmd;
    x0 = n_exc;
    r0 = n_err;
    for (int i = 0; i < 3; i++) begin
      send_byte(frm[i]);
      repeat (GAP) @(posedge i_clk);
    end
    #1;
    i_tx_busy = 1'b1;
    @(posedge i_clk);
    #1;
    i_tx_busy = 1'b0;
    repeat (50) @(posedge i_clk);
    send_frame(-1, 0);
    repeat (T35 + 10) @(posedge i_clk);
    #1;
    check_eq("txbusy cmd_pulses", n_cmd - c0, 0);
    check_eq("txbusy exc_pulses", n_exc - x0, 0);
    check_eq("txbusy err_pulses", n_err - r0, 0);
    run_frame("after_txbusy", -1, 0, 1, 0, 0);
    check_eq("after_txbusy func", o_func, 32'h03);

    // Reset pulse mid-frame.
    c0 = n_cmd;
    x0 = n_exc;
    r0 = n_err;
    for (int i = 0; i < 3; i++) begin
      send_byte(frm[i]);
      repeat (GAP) @(posedge i_clk);
    end
    #1;
    rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    check_eq("midrst func", o_func, 0);
    check_eq("midrst data", o_reg_data, 0);
    check_eq("midrst cmd_valid", o_cmd_valid, 0);
    rst_n = 1'b1;
    repeat (T35 + 10) @(posedge i_clk);
    #1;
    check_eq("midrst cmd_pulses", n_cmd - c0, 0);
    check_eq("midrst exc_pulses", n_exc - x0, 0);
    check_eq("midrst err_pulses", n_err - r0, 0);
    run_frame("after_rst", -1, 0, 1, 0, 0);
    check_eq("after_rst func", o_func, 32'h03);
    check_eq("after_rst data", o_reg_data, 32'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
